// File: rtl/alu_wb_pkg.sv
// Shared ALU/writeback definitions: sequencer state encoding, ALU op codes and fixed register addresses.
package alu_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_LSR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    localparam logic [4:0] R0_ADDR  = 5'd0;
    localparam int         RESULT_W = 16;
    localparam int         BYTE_W   = 8;

    function automatic logic [BYTE_W-1:0] sel_byte(input logic [RESULT_W-1:0] q, input logic hi);
        return hi ? q[RESULT_W-1:BYTE_W] : q[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Request bus from the decoder/ALU plus the register-file write port of the writeback sequencer.
interface alu_writeback_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic                  ready;
    logic [2:0]            op;
    logic                  wide;
    logic                  no_write;
    logic [REG_ADDR_W-1:0] dest;
    logic [15:0]           result;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [7:0]            rf_data;
    logic                  done;
    logic                  busy;

    modport master (
        output start, op, wide, no_write, dest, result,
        input  ready, rf_we, rf_addr, rf_data, done, busy
    );

    modport slave (
        input  start, op, wide, no_write, dest, result,
        output ready, rf_we, rf_addr, rf_data, done, busy
    );
endinterface

// File: rtl/d_flip_flop_multi_bit_en.sv
// Multi-bit register with load enable and synchronous active-high clear (clear wins over enable).
module d_flip_flop_multi_bit_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/alu_writeback.sv
// Writes a captured ALU result into the 8-bit register file: low byte one cycle after accept, high byte the next for wide/MUL.
// ready drops only in the low-byte cycle of a wide request; a new request is taken in the final write cycle with no bubble.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int         REG_ADDR_W = 5,
    parameter logic [2:0] MUL_OP     = 3'b010
) (
    input  logic          clk,
    input  logic          reset,
    alu_writeback_if.slave bus
);
    localparam int CAP_W = RESULT_W + REG_ADDR_W + 1;

    wb_state_t             state_q, state_d;
    logic                  done_nw_q, done_nw_d;

    logic                  is_mul;
    logic                  eff_wide;
    logic [REG_ADDR_W-1:0] eff_addr;
    logic                  ready_int;
    logic                  accept;
    logic                  accept_wr;

    logic [CAP_W-1:0]      cap_d;
    logic [CAP_W-1:0]      cap_q;
    logic [RESULT_W-1:0]   cap_result;
    logic [REG_ADDR_W-1:0] cap_addr;
    logic                  cap_wide;

    logic                  rf_we_int;
    logic [REG_ADDR_W-1:0] rf_addr_int;
    logic [BYTE_W-1:0]     rf_data_int;
    logic                  done_int;

    assign is_mul   = (bus.op == MUL_OP);
    assign eff_addr = is_mul ? REG_ADDR_W'(R0_ADDR) : bus.dest;
    assign eff_wide = bus.wide | is_mul;

    // ready depends only on registered state, so accept never loops back through the decode below.
    assign ready_int = (state_q == IDLE) | ((state_q == WR_LO) & ~cap_wide) | (state_q == WR_HI);
    assign accept    = bus.start & ready_int;
    assign accept_wr = accept & ~bus.no_write;

    assign cap_d = {bus.result, eff_addr, eff_wide};
    assign {cap_result, cap_addr, cap_wide} = cap_q;

    d_flip_flop_multi_bit_en #(
        .WIDTH (CAP_W)
    ) u_capture (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     (cap_d),
        .q     (cap_q)
    );

    assign done_nw_d = accept & bus.no_write;

    always_comb begin
        state_d     = state_q;
        rf_we_int   = 1'b0;
        rf_addr_int = '0;
        rf_data_int = '0;
        done_int    = done_nw_q;

        case (state_q)
            IDLE: begin
                if (accept_wr) begin
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                rf_we_int   = 1'b1;
                rf_addr_int = cap_addr;
                rf_data_int = sel_byte(cap_result, 1'b0);
                if (cap_wide) begin
                    state_d = WR_HI;
                end else begin
                    done_int = 1'b1;
                    state_d  = accept_wr ? WR_LO : IDLE;
                end
            end
            WR_HI: begin
                rf_we_int   = 1'b1;
                rf_addr_int = cap_addr + REG_ADDR_W'(1);
                rf_data_int = sel_byte(cap_result, 1'b1);
                done_int    = 1'b1;
                state_d     = accept_wr ? WR_LO : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done_nw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_nw_q <= done_nw_d;
        end
    end

    assign bus.ready   = ready_int;
    assign bus.rf_we   = rf_we_int;
    assign bus.rf_addr = rf_addr_int;
    assign bus.rf_data = rf_data_int;
    assign bus.done    = done_int;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_alu_writeback.sv
// Directed scenarios plus a randomized run against a cycle-indexed schedule of expected register writes.
module tb_alu_writeback;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_writeback_if #(.REG_ADDR_W(5)) bus ();

    alu_writeback #(
        .REG_ADDR_W (5),
        .MUL_OP     (3'b010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {rf_we, rf_addr, rf_data, done, busy, ready}
    function automatic logic [16:0] outs();
        return {bus.rf_we, bus.rf_addr, bus.rf_data, bus.done, bus.busy, bus.ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.wide     = 1'b0;
        bus.no_write = 1'b0;
        bus.dest     = 5'd0;
        bus.result   = 16'h0000;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic wide, input logic nw,
                             input logic [4:0] dest, input logic [15:0] res);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.wide     = wide;
        bus.no_write = nw;
        bus.dest     = dest;
        bus.result   = res;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_total++;
        if (outs() !== 17'b0_00000_00000000_0_0_1) $display("FAIL reset_state got=%h exp=%h", outs(), 17'b0_00000_00000000_0_0_1);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (outs() !== 17'b0_00000_00000000_0_0_1) $display("FAIL reset_release got=%h exp=%h", outs(), 17'b0_00000_00000000_0_0_1);
        else n_pass++;
    endtask

    task automatic test_add8();
        drive_req(3'd0, 1'b0, 1'b0, 5'd16, 16'h00A5);
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL add8_ready got=%b exp=1", bus.ready);
        else n_pass++;
        tick();
        idle_inputs();
        bus.result = 16'hFFFF;
        n_total++;
        if (outs() !== {1'b1, 5'd16, 8'hA5, 1'b1, 1'b1, 1'b1}) $display("FAIL add8_write got=%h exp=%h", outs(), {1'b1, 5'd16, 8'hA5, 1'b1, 1'b1, 1'b1});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL add8_after got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_mul();
        drive_req(3'd2, 1'b0, 1'b0, 5'd20, 16'h1234);
        tick();
        idle_inputs();
        n_total++;
        if (outs() !== {1'b1, 5'd0, 8'h34, 1'b0, 1'b1, 1'b0}) $display("FAIL mul_lo got=%h exp=%h", outs(), {1'b1, 5'd0, 8'h34, 1'b0, 1'b1, 1'b0});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b1, 5'd1, 8'h12, 1'b1, 1'b1, 1'b1}) $display("FAIL mul_hi got=%h exp=%h", outs(), {1'b1, 5'd1, 8'h12, 1'b1, 1'b1, 1'b1});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL mul_after got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_wide_wrap();
        drive_req(3'd0, 1'b1, 1'b0, 5'd31, 16'hBEEF);
        tick();
        idle_inputs();
        n_total++;
        if (outs() !== {1'b1, 5'd31, 8'hEF, 1'b0, 1'b1, 1'b0}) $display("FAIL wrap_lo got=%h exp=%h", outs(), {1'b1, 5'd31, 8'hEF, 1'b0, 1'b1, 1'b0});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b1, 5'd0, 8'hBE, 1'b1, 1'b1, 1'b1}) $display("FAIL wrap_hi got=%h exp=%h", outs(), {1'b1, 5'd0, 8'hBE, 1'b1, 1'b1, 1'b1});
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int          dones;
        logic [7:0]  d;
        dones = 0;
        for (int k = 1; k <= 3; k++) begin
            d = 8'(k * 17);
            drive_req(3'd5, 1'b0, 1'b0, 5'(k), {8'h00, d});
            tick();
            n_total++;
            if (outs() !== {1'b1, 5'(k), d, 1'b1, 1'b1, 1'b1}) $display("FAIL b2b_write%0d got=%h exp=%h", k, outs(), {1'b1, 5'(k), d, 1'b1, 1'b1, 1'b1});
            else n_pass++;
            if (bus.done === 1'b1) dones++;
        end
        idle_inputs();
        tick();
        if (bus.done === 1'b1) dones++;
        n_total++;
        if (dones !== 3) $display("FAIL b2b_done_count got=%0d exp=3", dones);
        else n_pass++;
    endtask

    task automatic test_no_write();
        drive_req(3'd1, 1'b0, 1'b1, 5'd5, 16'h5555);
        tick();
        idle_inputs();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1}) $display("FAIL nowrite_done got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL nowrite_after got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        drive_req(3'd2, 1'b0, 1'b0, 5'd7, 16'hABCD);
        tick();
        idle_inputs();
        n_total++;
        if (outs() !== {1'b1, 5'd0, 8'hCD, 1'b0, 1'b1, 1'b0}) $display("FAIL abort_lo got=%h exp=%h", outs(), {1'b1, 5'd0, 8'hCD, 1'b0, 1'b1, 1'b0});
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL abort_next got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
        tick();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL abort_quiet got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
        // a request presented together with reset must be dropped
        drive_req(3'd0, 1'b0, 1'b0, 5'd9, 16'h0077);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        n_total++;
        if (outs() !== {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) $display("FAIL start_in_reset got=%h exp=%h", outs(), {1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    localparam int NR = 600;
    logic       m_we   [NR+3];
    logic [4:0] m_addr [NR+3];
    logic [7:0] m_data [NR+3];
    logic       m_done [NR+3];

    task automatic test_random();
        logic [16:0] exp;
        logic        st, r_wide, r_nw, r_rst, acc, ew;
        logic [2:0]  r_op;
        logic [4:0]  r_dest, ea;
        logic [15:0] r_res;
        for (int i = 0; i < NR + 3; i++) begin
            m_we[i] = 1'b0; m_addr[i] = 5'd0; m_data[i] = 8'd0; m_done[i] = 1'b0;
        end
        for (int c = 0; c < NR; c++) begin
            exp = {m_we[c], m_we[c] ? m_addr[c] : 5'd0, m_we[c] ? m_data[c] : 8'd0,
                   m_done[c], m_we[c], !m_we[c+1]};
            n_total++;
            if (outs() !== exp) $display("FAIL random_cycle%0d got=%h exp=%h", c, outs(), exp);
            else n_pass++;

            st     = ($urandom_range(0, 3) != 0);
            r_op   = 3'($urandom_range(0, 7));
            r_wide = 1'($urandom_range(0, 1));
            r_nw   = ($urandom_range(0, 5) == 0);
            r_dest = 5'($urandom_range(0, 31));
            r_res  = 16'($urandom);
            r_rst  = ($urandom_range(0, 39) == 0);
            bus.start = st; bus.op = r_op; bus.wide = r_wide; bus.no_write = r_nw;
            bus.dest = r_dest; bus.result = r_res;
            reset = r_rst;

            acc = st && !m_we[c+1] && !r_rst;
            if (r_rst) begin
                m_we[c+1] = 1'b0; m_done[c+1] = 1'b0;
                m_we[c+2] = 1'b0; m_done[c+2] = 1'b0;
            end else if (acc) begin
                if (r_nw) begin
                    m_done[c+1] = 1'b1;
                end else begin
                    ea = (r_op == 3'd2) ? 5'd0 : r_dest;
                    ew = r_wide || (r_op == 3'd2);
                    m_we[c+1]   = 1'b1;
                    m_addr[c+1] = ea;
                    m_data[c+1] = r_res[7:0];
                    if (ew) begin
                        m_we[c+2]   = 1'b1;
                        m_addr[c+2] = ea + 5'd1;
                        m_data[c+2] = r_res[15:8];
                        m_done[c+2] = 1'b1;
                    end else begin
                        m_done[c+1] = 1'b1;
                    end
                end
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_add8();
        test_mul();
        test_wide_wrap();
        test_back_to_back();
        test_no_write();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
